// File: rtl/sys1_input_ctrl.sv
// sys1_input_ctrl: PS/2 + joystick input conditioning for the System 1 core.
// Ports: clk_sys/reset (sync, active-high); ps2_key event word; joystk1/2 pads
//   (active-high); vblank; cabinet select; INP0/INP1/INP2 registered active-low words.
// Latency: joystick -> INP* 1 clock, key event -> INP* 2 clocks, coin bit 1 clock after FSM.
module sys1_input_ctrl #(
  parameter int COIN_FRAMES = 3,
  parameter int GAP_FRAMES  = 2
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystk1,
  input  logic [15:0] joystk2,
  input  logic        vblank,
  input  logic        cabinet,
  output logic [7:0]  INP0,
  output logic [7:0]  INP1,
  output logic [7:0]  INP2
);

  localparam logic [3:0] COIN_INIT = 4'(COIN_FRAMES);
  localparam logic [3:0] GAP_INIT  = 4'(GAP_FRAMES);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} coin_state_t;

  // Player vectors use the joystick bit order: [0]R [1]L [2]D [3]U [4]Trig1 [5]Trig2
  logic [5:0]  keys1, keys2;
  logic        key_start1, key_start2, key_f1, key_f2, key_coin1, key_coin2;
  logic        toggle_hist;
  logic        key_evt;
  logic        pressed;

  logic [5:0]  p1, p2;
  logic        start1, start2, coin_req;
  logic        coin_req_q, vb_q, vb_rise;
  coin_state_t coin_state;
  logic [3:0]  coin_cnt;

  // Pad bits above the coin bit are not used by this core.
  logic        unused_pad;
  assign unused_pad = ^{joystk1[15:9], joystk2[15:9]};

  assign key_evt = ps2_key[10] != toggle_hist;
  assign pressed = ps2_key[9];

  always_ff @(posedge clk_sys) begin
    toggle_hist <= ps2_key[10];
    if (reset) begin
      keys1      <= '0;
      keys2      <= '0;
      key_start1 <= 1'b0;
      key_start2 <= 1'b0;
      key_f1     <= 1'b0;
      key_f2     <= 1'b0;
      key_coin1  <= 1'b0;
      key_coin2  <= 1'b0;
    end else if (key_evt) begin
      // Arrow keys match with or without the extended prefix.
      case (ps2_key[7:0])
        8'h75:   keys1[3] <= pressed;
        8'h72:   keys1[2] <= pressed;
        8'h6B:   keys1[1] <= pressed;
        8'h74:   keys1[0] <= pressed;
        default: begin
          if (!ps2_key[8]) begin
            case (ps2_key[7:0])
              8'h29:   keys1[4]   <= pressed;
              8'h14:   keys1[5]   <= pressed;
              8'h05:   key_f1     <= pressed;
              8'h06:   key_f2     <= pressed;
              8'h16:   key_start1 <= pressed;
              8'h1E:   key_start2 <= pressed;
              8'h2E:   key_coin1  <= pressed;
              8'h36:   key_coin2  <= pressed;
              8'h2D:   keys2[3]   <= pressed;
              8'h2B:   keys2[2]   <= pressed;
              8'h23:   keys2[1]   <= pressed;
              8'h34:   keys2[0]   <= pressed;
              8'h1C:   keys2[4]   <= pressed;
              8'h1B:   keys2[5]   <= pressed;
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  // Upright cabinets share one control panel, so P2 inputs also drive P1.
  assign p2       = keys2 | joystk2[5:0];
  assign p1       = keys1 | joystk1[5:0] | (cabinet ? 6'd0 : p2);
  assign start1   = key_start1 | key_f1 | joystk1[6] | joystk2[6];
  assign start2   = key_start2 | key_f2 | joystk1[7] | joystk2[7];
  assign coin_req = key_f1 | key_f2 | key_coin1 | key_coin2 | joystk1[8] | joystk2[8];
  assign vb_rise  = vblank & ~vb_q;

  // Opposing directions held together cancel out.
  function automatic logic [5:0] socd(input logic [5:0] p);
    logic [5:0] o;
    o = p;
    if (p[0] && p[1]) o[1:0] = 2'b00;
    if (p[2] && p[3]) o[3:2] = 2'b00;
    return o;
  endfunction

  function automatic logic [7:0] pack_player(input logic [5:0] p);
    return ~{p[1], p[0], p[3], p[2], 1'b0, p[5], p[4], 1'b0};
  endfunction

  // Coin shaper: one pulse of COIN_FRAMES frames per fresh request edge, then a
  // forced-low gap; request edges arriving while busy are discarded.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      coin_state <= IDLE;
      coin_cnt   <= '0;
      coin_req_q <= 1'b0;
      vb_q       <= vblank;
      INP0       <= 8'hFF;
      INP1       <= 8'hFF;
      INP2       <= 8'hFF;
    end else begin
      coin_req_q <= coin_req;
      vb_q       <= vblank;
      case (coin_state)
        IDLE: begin
          if (coin_req && !coin_req_q) begin
            coin_state <= PULSE;
            coin_cnt   <= COIN_INIT;
          end
        end
        PULSE: begin
          if (vb_rise) begin
            if (coin_cnt <= 4'd1) begin
              coin_state <= GAP;
              coin_cnt   <= GAP_INIT;
            end else begin
              coin_cnt <= coin_cnt - 4'd1;
            end
          end
        end
        GAP: begin
          if (vb_rise) begin
            if (coin_cnt <= 4'd1) begin
              coin_state <= IDLE;
              coin_cnt   <= '0;
            end else begin
              coin_cnt <= coin_cnt - 4'd1;
            end
          end
        end
        default: begin
          coin_state <= IDLE;
          coin_cnt   <= '0;
        end
      endcase
      INP0 <= pack_player(socd(p1));
      INP1 <= pack_player(socd(p2));
      INP2 <= ~{2'b00, start2, start1, 3'b000, coin_state == PULSE};
    end
  end

endmodule

// File: tb/tb_sys1_input_ctrl.sv
// Bench for sys1_input_ctrl: directed scenarios plus randomized key/joystick
// traffic checked against a name-based key model; vblank runs as an 8-clock frame.
module tb_sys1_input_ctrl;
  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic [10:0] ps2_key = '0;
  logic [15:0] joystk1 = '0;
  logic [15:0] joystk2 = '0;
  logic        vblank  = 1'b0;
  logic        cabinet = 1'b0;
  logic [7:0]  INP0, INP1, INP2;

  int total = 0;
  int bad   = 0;

  // vblank frame generator and coin monitors
  int cyc = 0;
  bit vb_raised = 0;
  int vb_low = 0;
  int pulses = 0;
  bit prev_coin = 1;

  bit tog = 0;
  bit kst[string];

  sys1_input_ctrl #(.COIN_FRAMES(3), .GAP_FRAMES(2)) dut (
    .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key),
    .joystk1(joystk1), .joystk2(joystk2), .vblank(vblank),
    .cabinet(cabinet), .INP0(INP0), .INP1(INP1), .INP2(INP2)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    bit raise;
    @(posedge clk_sys);
    #1;
    // A vblank rise counts toward the pulse if the coin is still low one
    // clock after the DUT saw it (the output lags the state by one clock).
    if (vb_raised && INP2[0] == 1'b0) vb_low++;
    if (prev_coin && !INP2[0]) pulses++;
    prev_coin = INP2[0];
    cyc++;
    raise     = ((cyc % 8) < 3) && !vblank;
    vblank    = (cyc % 8) < 3;
    vb_raised = raise;
  endtask

  task automatic clear_monitor();
    vb_low = 0;
    pulses = 0;
    prev_coin = INP2[0];
  endtask

  function automatic string kname(input logic [8:0] c);
    case (c[7:0])
      8'h75: return "up";
      8'h72: return "down";
      8'h6B: return "left";
      8'h74: return "right";
      default: ;
    endcase
    if (c[8]) return "";
    case (c[7:0])
      8'h29: return "trig1";
      8'h14: return "trig2";
      8'h05: return "f1";
      8'h06: return "f2";
      8'h16: return "start1";
      8'h1E: return "start2";
      8'h2E: return "coin1";
      8'h36: return "coin2";
      8'h2D: return "up2";
      8'h2B: return "down2";
      8'h23: return "left2";
      8'h34: return "right2";
      8'h1C: return "trig1_2";
      8'h1B: return "trig2_2";
      default: return "";
    endcase
  endfunction

  function automatic bit kget(input string n);
    return kst.exists(n) ? kst[n] : 1'b0;
  endfunction

  task automatic send_key(input bit pr, input logic [8:0] code);
    string n;
    tog = ~tog;
    ps2_key = {tog, pr, code};
    n = kname(code);
    if (n != "") kst[n] = pr;
  endtask

  function automatic logic [7:0] pword(input bit l, input bit r, input bit u,
                                       input bit d, input bit t1, input bit t2);
    bit ll, rr, uu, dd;
    ll = l && !r; rr = r && !l;
    uu = u && !d; dd = d && !u;
    return ~{ll, rr, uu, dd, 1'b0, t2, t1, 1'b0};
  endfunction

  task automatic model(output logic [7:0] e0, output logic [7:0] e1, output logic [7:0] e2);
    bit l2, r2, u2, d2, a2, b2, l1, r1, u1, d1, a1, b1;
    l2 = kget("left2")  | joystk2[1];
    r2 = kget("right2") | joystk2[0];
    u2 = kget("up2")    | joystk2[3];
    d2 = kget("down2")  | joystk2[2];
    a2 = kget("trig1_2")| joystk2[4];
    b2 = kget("trig2_2")| joystk2[5];
    l1 = kget("left")  | joystk1[1] | (!cabinet && l2);
    r1 = kget("right") | joystk1[0] | (!cabinet && r2);
    u1 = kget("up")    | joystk1[3] | (!cabinet && u2);
    d1 = kget("down")  | joystk1[2] | (!cabinet && d2);
    a1 = kget("trig1") | joystk1[4] | (!cabinet && a2);
    b1 = kget("trig2") | joystk1[5] | (!cabinet && b2);
    e0 = pword(l1, r1, u1, d1, a1, b1);
    e1 = pword(l2, r2, u2, d2, a2, b2);
    e2 = 8'hFF;
    if (kget("start1") || kget("f1") || joystk1[6] || joystk2[6]) e2[4] = 1'b0;
    if (kget("start2") || kget("f2") || joystk1[7] || joystk2[7]) e2[5] = 1'b0;
    if (kget("f1") || kget("f2") || kget("coin1") || kget("coin2") || joystk1[8] || joystk2[8])
      e2[0] = 1'b0;  // only valid while no coin request is made
  endtask

  task automatic do_reset();
    joystk1 = '0;
    joystk2 = '0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    kst.delete();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tog = 1'b1;
    ps2_key = {1'b1, 1'b1, 9'h029};
    tick(); tick();
    total++; if (INP0 !== 8'hFF) begin bad++; $display("FAIL reset_inp0: got %h want ff", INP0); end
    total++; if (INP1 !== 8'hFF) begin bad++; $display("FAIL reset_inp1: got %h want ff", INP1); end
    total++; if (INP2 !== 8'hFF) begin bad++; $display("FAIL reset_inp2: got %h want ff", INP2); end
    reset = 1'b0;
    tick(); tick(); tick();
    total++; if (INP0 !== 8'hFF) begin bad++; $display("FAIL no_ghost_event: got %h want ff", INP0); end
  endtask

  task automatic test_key_trig();
    do_reset();
    send_key(1'b1, 9'h029);
    tick();
    total++; if (INP0 !== 8'hFF) begin bad++; $display("FAIL key_lat1: got %h want ff", INP0); end
    tick();
    total++; if (INP0 !== 8'hFD) begin bad++; $display("FAIL key_press: got %h want fd", INP0); end
    send_key(1'b0, 9'h029);
    tick(); tick();
    total++; if (INP0 !== 8'hFF) begin bad++; $display("FAIL key_release: got %h want ff", INP0); end
  endtask

  task automatic test_cabinet();
    do_reset();
    cabinet = 1'b0;
    joystk2 = 16'h0002;
    tick();
    total++; if (INP0 !== 8'h7F) begin bad++; $display("FAIL upright_p1: got %h want 7f", INP0); end
    total++; if (INP1 !== 8'h7F) begin bad++; $display("FAIL upright_p2: got %h want 7f", INP1); end
    cabinet = 1'b1;
    tick();
    total++; if (INP0 !== 8'hFF) begin bad++; $display("FAIL cocktail_p1: got %h want ff", INP0); end
    total++; if (INP1 !== 8'h7F) begin bad++; $display("FAIL cocktail_p2: got %h want 7f", INP1); end
    joystk2 = '0;
    tick();
  endtask

  task automatic test_socd();
    do_reset();
    cabinet = 1'b1;
    send_key(1'b1, 9'h174);
    joystk1 = 16'h0002;
    tick();
    total++; if (INP0 !== 8'h7F) begin bad++; $display("FAIL socd_joy_first: got %h want 7f", INP0); end
    tick();
    total++; if (INP0 !== 8'hFF) begin bad++; $display("FAIL socd_clear: got %h want ff", INP0); end
    joystk1 = '0;
    tick();
    total++; if (INP0 !== 8'hBF) begin bad++; $display("FAIL socd_release: got %h want bf", INP0); end
    send_key(1'b0, 9'h174);
    tick(); tick();
  endtask

  task automatic test_coin_hold();
    do_reset();
    clear_monitor();
    joystk1 = 16'h0100;
    repeat (160) tick();
    total++; if (pulses != 1) begin bad++; $display("FAIL hold_pulses: got %0d want 1", pulses); end
    total++; if (vb_low != 3) begin bad++; $display("FAIL hold_frames: got %0d want 3", vb_low); end
    total++; if (INP2 !== 8'hFF) begin bad++; $display("FAIL hold_end: got %h want ff", INP2); end
    joystk1 = '0;
    repeat (4) tick();
  endtask

  task automatic test_coin_double();
    do_reset();
    clear_monitor();
    joystk2 = 16'h0100; repeat (4) tick();
    joystk2 = '0;       repeat (8) tick();
    joystk2 = 16'h0100; repeat (4) tick();
    joystk2 = '0;       repeat (48) tick();
    total++; if (pulses != 1) begin bad++; $display("FAIL double_dropped: got %0d want 1", pulses); end
    send_key(1'b1, 9'h02E); repeat (4) tick();
    send_key(1'b0, 9'h02E); repeat (40) tick();
    total++; if (pulses != 2) begin bad++; $display("FAIL double_pulses: got %0d want 2", pulses); end
    total++; if (vb_low != 6) begin bad++; $display("FAIL double_frames: got %0d want 6", vb_low); end
  endtask

  task automatic test_reset_midpulse();
    do_reset();
    joystk1 = 16'h0100; repeat (4) tick();
    joystk1 = '0;       repeat (4) tick();
    total++; if (INP2[0] !== 1'b0) begin bad++; $display("FAIL midpulse_active: got %b want 0", INP2[0]); end
    reset = 1'b1;
    tick();
    total++; if (INP2 !== 8'hFF) begin bad++; $display("FAIL midpulse_reset: got %h want ff", INP2); end
    reset = 1'b0;
    kst.delete();
    tick();
    clear_monitor();
    joystk1 = 16'h0100; repeat (4) tick();
    joystk1 = '0;       repeat (40) tick();
    total++; if (pulses != 1) begin bad++; $display("FAIL after_reset_pulses: got %0d want 1", pulses); end
    total++; if (vb_low != 3) begin bad++; $display("FAIL after_reset_frames: got %0d want 3", vb_low); end
  endtask

  task automatic test_random();
    logic [8:0] codes [20] = '{9'h075, 9'h175, 9'h072, 9'h172, 9'h06B, 9'h16B, 9'h074,
                               9'h174, 9'h029, 9'h014, 9'h016, 9'h01E, 9'h02D, 9'h02B,
                               9'h023, 9'h034, 9'h01C, 9'h01B, 9'h129, 9'h0AA};
    logic [7:0] e0, e1, e2;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      joystk1 = 16'($urandom & 32'h00FF);
      joystk2 = 16'($urandom & 32'h00FF);
      if ($urandom_range(0, 7) == 0) cabinet = ~cabinet;
      model(e0, e1, e2);
      if ($urandom_range(0, 2) == 0)
        send_key(1'($urandom_range(0, 1)), codes[$urandom_range(0, 19)]);
      tick();
      total++; if (INP0 !== e0) begin bad++; $display("FAIL rand_inp0 #%0d: got %h want %h", i, INP0, e0); end
      total++; if (INP1 !== e1) begin bad++; $display("FAIL rand_inp1 #%0d: got %h want %h", i, INP1, e1); end
      total++; if (INP2 !== e2) begin bad++; $display("FAIL rand_inp2 #%0d: got %h want %h", i, INP2, e2); end
    end
  endtask

  initial begin
    test_reset();
    test_key_trig();
    test_cabinet();
    test_socd();
    test_coin_hold();
    test_coin_double();
    test_reset_midpulse();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
